// File: rtl/tx_arb_pkg.sv
// Shared types and default sizes for the outbound GPIO message arbiter.
package tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } tx_arb_state_t;

    localparam int MSG_W_DEF = 128;
    localparam int NREQ_DEF  = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr,
// wrapping modulo NREQ.
module rr_pick #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  pick,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int cand;

    always_comb begin
        pick  = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!valid && req[cand]) begin
                valid      = 1'b1;
                idx        = IDX_W'(cand);
                pick[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_message_arbiter.sv
// Round-robin arbiter sharing the GPIO message channel; drives the data_ready/done
// handshake. Optional handshake watchdog enabled by TX_ARB_TIMEOUT_EN.
module tx_message_arbiter
    import tx_arb_pkg::*;
#(
    parameter  int NREQ        = NREQ_DEF,
    parameter  int MSG_W       = MSG_W_DEF,
    parameter  int TIMEOUT_CYC = 100_000_000,
    localparam int IDX_W       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*MSG_W-1:0] msg_in,
    output logic [NREQ-1:0]       grant,
    output logic [MSG_W-1:0]      message_out,
    output logic                  data_ready,
    input  logic                  done,
    output logic                  busy,
    output logic [IDX_W-1:0]      last_src,
    output logic                  timeout
);

    tx_arb_state_t    state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [NREQ-1:0]  grant_nxt;
    logic [MSG_W-1:0] msg_nxt;
    logic             dr_nxt;
    logic [IDX_W-1:0] last_nxt;
    logic             to_nxt;
    logic             wd_hit;

    logic [NREQ-1:0]  pick;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;

    // done comes from the slow GPIO domain: two-flop synchronizer
    logic done_p0, done_s;

    always_ff @(posedge clock) begin
        if (reset) begin
            done_p0 <= 1'b0;
            done_s  <= 1'b0;
        end else begin
            done_p0 <= done;
            done_s  <= done_p0;
        end
    end

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .pick  (pick),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

`ifdef TX_ARB_TIMEOUT_EN
    logic [31:0] wd_cnt;

    // Counter sits at zero outside SEND, so each message starts a fresh count
    always_ff @(posedge clock) begin
        if (reset || state != SEND) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 32'd1;
        end
    end

    assign wd_hit = (wd_cnt == 32'(TIMEOUT_CYC - 1));
`else
    logic cfg_unused;
    assign cfg_unused = (TIMEOUT_CYC == 0);
    assign wd_hit     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        grant_nxt = '0;
        msg_nxt   = message_out;
        dr_nxt    = data_ready;
        last_nxt  = last_src;
        to_nxt    = 1'b0;
        case (state)
            IDLE: begin
                // A done still high from the previous message blocks new grants
                if (pick_vld && !done_s) begin
                    grant_nxt = pick;
                    msg_nxt   = msg_in[pick_idx*MSG_W +: MSG_W];
                    last_nxt  = pick_idx;
                    ptr_nxt   = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                    dr_nxt    = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (done_s) begin
                    dr_nxt    = 1'b0;
                    state_nxt = RELEASE;
                end else if (wd_hit) begin
                    dr_nxt    = 1'b0;
                    to_nxt    = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!done_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                dr_nxt    = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            message_out <= '0;
            data_ready  <= 1'b0;
            last_src    <= '0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            grant       <= grant_nxt;
            message_out <= msg_nxt;
            data_ready  <= dr_nxt;
            last_src    <= last_nxt;
            timeout     <= to_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_tx_message_arbiter.sv
// Directed bench for tx_message_arbiter with a cycle-level reference model.
`timescale 1ns/1ps
module tb_tx_message_arbiter;

    localparam int NREQ  = 4;
    localparam int MSG_W = 128;
    localparam int TO    = 16;
`ifdef TX_ARB_TIMEOUT_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  done  = 1'b0;
    logic [NREQ-1:0]       req   = '0;
    logic [MSG_W-1:0]      msgs [NREQ];
    logic [NREQ*MSG_W-1:0] msg_in;
    logic [NREQ-1:0]       grant;
    logic [MSG_W-1:0]      message_out;
    logic                  data_ready, busy, timeout;
    logic [1:0]            last_src;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    assign msg_in = {msgs[3], msgs[2], msgs[1], msgs[0]};

    tx_message_arbiter #(.NREQ(NREQ), .MSG_W(MSG_W), .TIMEOUT_CYC(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .msg_in      (msg_in),
        .grant       (grant),
        .message_out (message_out),
        .data_ready  (data_ready),
        .done        (done),
        .busy        (busy),
        .last_src    (last_src),
        .timeout     (timeout)
    );

    task automatic check(input string name, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: phase 0 = idle, 1 = sending, 2 = waiting for done to clear
    bit               m_valid = 1'b0;
    int               m_phase, m_ptr, m_last, m_wd, m_sel;
    logic [NREQ-1:0]  m_grant;
    logic [MSG_W-1:0] m_msg;
    bit               m_dr, m_to, m_ds1, m_ds2;

    initial begin
        forever begin
            @(posedge clock);
            if (reset) begin
                m_valid = 1'b1;
                m_phase = 0; m_ptr = 0; m_last = 0; m_wd = 0;
                m_grant = '0; m_msg = '0; m_dr = 1'b0; m_to = 1'b0;
                m_ds1 = 1'b0; m_ds2 = 1'b0;
            end else begin
                m_grant = '0;
                m_to    = 1'b0;
                case (m_phase)
                    0: if (req != 0 && !m_ds2) begin
                        m_sel = -1;
                        for (int k = 0; k < NREQ; k++)
                            if (m_sel < 0 && req[(m_ptr + k) % NREQ]) m_sel = (m_ptr + k) % NREQ;
                        m_grant[m_sel] = 1'b1;
                        m_msg   = msgs[m_sel];
                        m_last  = m_sel;
                        m_ptr   = (m_sel + 1) % NREQ;
                        m_dr    = 1'b1;
                        m_wd    = 0;
                        m_phase = 1;
                    end
                    1: begin
                        if (m_ds2) begin
                            m_dr = 1'b0; m_phase = 2;
                        end else if (WD_ON && m_wd == TO - 1) begin
                            m_dr = 1'b0; m_to = 1'b1; m_phase = 2;
                        end else begin
                            m_wd++;
                        end
                    end
                    default: if (!m_ds2) m_phase = 0;
                endcase
                m_ds2 = m_ds1;
                m_ds1 = done;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (m_valid) begin
                check("m_grant",       MSG_W'(grant),      MSG_W'(m_grant));
                check("m_message_out", message_out,        m_msg);
                check("m_data_ready",  MSG_W'(data_ready), MSG_W'(m_dr));
                check("m_busy",        MSG_W'(busy),       MSG_W'(m_phase != 0));
                check("m_last_src",    MSG_W'(last_src),   MSG_W'(m_last));
                check("m_timeout",     MSG_W'(timeout),    MSG_W'(m_to));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_grant(output int idx);
        int n = 0;
        idx = -1;
        while (grant == 0 && n < 64) begin
            tick(1);
            n++;
        end
        check("grant_seen", MSG_W'(grant != 0), MSG_W'(1));
        for (int b = 0; b < NREQ; b++)
            if (grant[b]) idx = b;
    endtask

    task automatic finish_msg();
        int n = 0;
        done = 1'b1;
        while (data_ready && n < 64) begin
            tick(1);
            n++;
        end
        check("dr_drop_seen", MSG_W'(data_ready), MSG_W'(0));
        done = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 64) begin
            tick(1);
            n++;
        end
        check("idle_seen", MSG_W'(busy), MSG_W'(0));
    endtask

    initial begin
        #500_000;
        $display("FAIL global_time_limit: got running want finished");
        $fatal(1, "time limit");
    end

    logic [MSG_W-1:0] smiley;
    int               n, idx;
    logic [NREQ-1:0]  gacc;
    int               order [8];
    int               exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        smiley  = {":)", {14{8'h20}}};
        msgs[0] = "KEYBOARD MESSAGE";
        msgs[1] = "EMOJI PRESET 01 ";
        msgs[2] = smiley;
        msgs[3] = "CANNED HELLO!!!!";
        reset = 1'b1;
        tick(3);
        check("rst_grant",  MSG_W'(grant),      MSG_W'(0));
        check("rst_msg",    message_out,        '0);
        check("rst_dr",     MSG_W'(data_ready), MSG_W'(0));
        check("rst_busy",   MSG_W'(busy),       MSG_W'(0));
        check("rst_last",   MSG_W'(last_src),   MSG_W'(0));
        check("rst_tmo",    MSG_W'(timeout),    MSG_W'(0));
        reset = 1'b0;
        tick(1);

        // Single request from requester 2
        req = 4'b0100;
        tick(1);
        check("t1_grant", MSG_W'(grant),      MSG_W'(4'b0100));
        check("t1_msg",   message_out,        smiley);
        check("t1_dr",    MSG_W'(data_ready), MSG_W'(1));
        check("t1_last",  MSG_W'(last_src),   MSG_W'(2));
        check("t1_busy",  MSG_W'(busy),       MSG_W'(1));
        req = 4'b0000;
        msgs[2] = "XXXXXXXXXXXXXXXX";
        tick(3);
        check("t1_msg_hold", message_out, smiley);
        msgs[2] = smiley;

        // Completion latency, then a request blocked by a held done
        done = 1'b1;
        n = 0;
        do begin tick(1); n++; end while (data_ready && n < 20);
        check("done_latency", MSG_W'(n), MSG_W'(3));
        req  = 4'b0001;
        gacc = '0;
        for (int c = 0; c < 10; c++) begin tick(1); gacc |= grant; end
        check("no_grant_while_done", MSG_W'(gacc), MSG_W'(0));
        done = 1'b0;
        n = 0;
        do begin tick(1); n++; end while (grant == 0 && n < 20);
        check("regrant_latency", MSG_W'(n),        MSG_W'(4));
        check("regrant_grant",   MSG_W'(grant),    MSG_W'(4'b0001));
        check("regrant_last",    MSG_W'(last_src), MSG_W'(0));

        // Reset in SEND with requester 1 pending
        req = 4'b0010;
        tick(2);
        reset = 1'b1;
        tick(1);
        check("midrst_grant", MSG_W'(grant),      MSG_W'(0));
        check("midrst_msg",   message_out,        '0);
        check("midrst_dr",    MSG_W'(data_ready), MSG_W'(0));
        check("midrst_busy",  MSG_W'(busy),       MSG_W'(0));
        check("midrst_last",  MSG_W'(last_src),   MSG_W'(0));
        tick(1);
        reset = 1'b0;
        tick(1);
        check("postrst_grant", MSG_W'(grant),    MSG_W'(4'b0010));
        check("postrst_last",  MSG_W'(last_src), MSG_W'(1));
        check("postrst_msg",   message_out,      msgs[1]);
        req = 4'b0000;
        finish_msg();
        wait_idle();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;

        // All requests held: strict rotation
        req = 4'b1111;
        for (int m = 0; m < 8; m++) begin
            wait_grant(idx);
            order[m] = idx;
            if (idx >= 0) check("rr_msg", message_out, msgs[idx]);
            finish_msg();
        end
        for (int m = 0; m < 8; m++)
            check("rr_order", MSG_W'(order[m]), MSG_W'(exp_order[m]));
        req = 4'b0000;
        wait_idle();

        // done never arrives
        req = 4'b1000;
        wait_grant(idx);
        req = 4'b0000;
`ifdef TX_ARB_TIMEOUT_EN
        n = 0;
        while (!timeout && n < 40) begin tick(1); n++; end
        check("tmo_latency", MSG_W'(n),          MSG_W'(16));
        check("tmo_dr",      MSG_W'(data_ready), MSG_W'(0));
        req = 4'b0100;
        wait_grant(idx);
        check("tmo_next_grant", MSG_W'(idx), MSG_W'(2));
        req = 4'b0000;
`else
        n = 0;
        for (int c = 0; c < 1000; c++) begin
            tick(1);
            if (data_ready && !timeout) n++;
        end
        check("no_wd_hold", MSG_W'(n), MSG_W'(1000));
`endif
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
